// File: rtl/multdiv_seq.sv
// Sequential signed multiply (radix-2 Booth) / divide (non-restoring) unit.
// One iteration per clock; fixed WIDTH+1 cycle latency after the start edge.
module multdiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             ctrl_busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic               mul_q, mul_d;
  logic               neg_q, neg_d;
  logic               dz_q, dz_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               exc_q, exc_d;
  logic               rdy_q, rdy_d;

  logic               start;
  logic [WIDTH:0]     hi_x, mx, bsum;
  logic [2*WIDTH:0]   booth_nx, div_nx;
  logic [WIDTH:0]     rsh, dx, rnew, rcor;
  logic [WIDTH-1:0]   a_mag, b_mag, quo;
  logic [WIDTH:0]     prod_up;

  assign start = ctrl_MULT | ctrl_DIV;

  // Datapath step logic for both algorithms, then FSM next-state selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    m_d     = m_q;
    mul_d   = mul_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    res_d   = res_q;
    exc_d   = exc_q;
    rdy_d   = 1'b0;

    hi_x = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
    mx   = {m_q[WIDTH-1], m_q};
    unique case (acc_q[1:0])
      2'b01:   bsum = hi_x + mx;
      2'b10:   bsum = hi_x - mx;
      default: bsum = hi_x;
    endcase
    booth_nx = {bsum[WIDTH:1], bsum[0], acc_q[WIDTH:2], acc_q[1]};

    rsh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    dx     = {1'b0, m_q};
    rnew   = acc_q[2*WIDTH] ? rsh + dx : rsh - dx;
    div_nx = {rnew, acc_q[WIDTH-2:0], ~rnew[WIDTH]};
    rcor   = acc_q[2*WIDTH] ? acc_q[2*WIDTH:WIDTH] + dx
                            : acc_q[2*WIDTH:WIDTH];
    quo    = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];

    prod_up = acc_q[2*WIDTH:WIDTH];
    a_mag   = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1)
                                     : data_operandA;
    b_mag   = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1)
                                     : data_operandB;

    if (start) begin
      state_d = S_RUN;
      cnt_d   = '0;
      mul_d   = ctrl_MULT;
      if (ctrl_MULT) begin
        m_d   = data_operandA;
        acc_d = {{WIDTH{1'b0}}, data_operandB, 1'b0};
        neg_d = 1'b0;
        dz_d  = 1'b0;
        ovf_d = 1'b0;
      end else begin
        m_d   = b_mag;
        acc_d = {{(WIDTH+1){1'b0}}, a_mag};
        neg_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        dz_d  = (data_operandB == '0);
        ovf_d = (data_operandA == INT_MIN) && (data_operandB == '1);
      end
    end else begin
      unique case (state_q)
        S_RUN: begin
          acc_d = mul_q ? booth_nx : div_nx;
          if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
          else                         cnt_d   = cnt_q + CW'(1);
        end
        S_FIX: begin
          state_d = S_IDLE;
          rdy_d   = 1'b1;
          if (mul_q) begin
            res_d = acc_q[WIDTH:1];
            exc_d = ~(&prod_up | ~|prod_up);
          end else begin
            acc_d = {rcor, acc_q[WIDTH-1:0]};
            res_d = dz_q ? '0 : quo;
            exc_d = dz_q | ovf_q;
          end
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers; reset clears everything and aborts any op.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      mul_q   <= 1'b0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      mul_q   <= mul_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      rdy_q   <= rdy_d;
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign ctrl_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_multdiv_seq.sv
// Scoreboard bench for multdiv_seq: reference results queued at issue,
// popped and compared on each result-ready pulse.
module tb_multdiv_seq;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         ctrl_reset = 1'b0;
  logic         ctrl_MULT = 1'b0;
  logic         ctrl_DIV = 1'b0;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic         ctrl_busy;

  typedef struct packed {
    logic [W-1:0] r;
    logic         e;
  } exp_t;

  exp_t sb[$];
  exp_t pe;
  int   nvec = 0;
  int   nerr = 0;

  multdiv_seq #(.WIDTH(W)) dut (
    .clock          (clock),
    .ctrl_reset     (ctrl_reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .ctrl_busy      (ctrl_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input bit mul, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t        x;
    logic signed [63:0] p;
    logic [32:0] up;
    int          sa, sbv;
    if (mul) begin
      p   = 64'($signed(a)) * 64'($signed(b));
      up  = p[63:31];
      x.r = p[31:0];
      x.e = !((&up) || !(|up));
    end else if (b == 0) begin
      x.r = '0;
      x.e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      x.r = 32'h8000_0000;
      x.e = 1'b1;
    end else begin
      sa  = a;
      sbv = b;
      x.r = sa / sbv;
      x.e = 1'b0;
    end
    return x;
  endfunction

  task automatic start(input bit mul, input bit dv,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    ctrl_MULT     = mul;
    ctrl_DIV      = dv;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_rdy(input string tag);
    int n   = 0;
    bit got = 0;
    while (n < 40 && !got) begin
      @(negedge clock);
      n++;
      if (n == 1) check({tag, "_busy1"}, 64'(ctrl_busy), 64'd1);
      if (data_resultRDY) got = 1;
    end
    check({tag, "_lat"}, 64'(n), 64'd33);
    if (got) check({tag, "_busy_end"}, 64'(ctrl_busy), 64'd0);
  endtask

  task automatic op(input bit mul, input logic [W-1:0] a,
                    input logic [W-1:0] b, input string tag);
    sb.push_back(model(mul, a, b));
    start(mul, !mul, a, b);
    wait_rdy(tag);
  endtask

  always @(negedge clock) begin
    if (ctrl_reset && data_resultRDY) begin
      if (sb.size() == 0) begin
        check("spurious_rdy", 64'd1, 64'd0);
      end else begin
        pe = sb.pop_front();
        check("result", 64'(data_result), 64'(pe.r));
        check("exc", 64'(data_exception), 64'(pe.e));
      end
    end
  end

  initial begin
    repeat (3) @(negedge clock);
    check("rst_busy", 64'(ctrl_busy), 64'd0);
    check("rst_rdy", 64'(data_resultRDY), 64'd0);
    check("rst_res", 64'(data_result), 64'd0);
    check("rst_exc", 64'(data_exception), 64'd0);
    ctrl_reset = 1'b1;
    repeat (2) @(negedge clock);

    op(1, 32'd3, 32'hFFFF_FFFC, "mul_3x-4");
    op(1, 32'h0001_0000, 32'h0001_0000, "mul_ovf");
    op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_m1m1");
    op(1, 32'h8000_0000, 32'h8000_0000, "mul_minmin");
    op(1, 32'h8000_0000, 32'h0000_0001, "mul_min1");
    op(0, 32'hFFFF_FFF9, 32'd2, "div_-7/2");
    op(0, 32'd100, 32'd7, "div_100/7");
    op(0, 32'd5, 32'd0, "div_by0");
    op(0, 32'h8000_0000, 32'hFFFF_FFFF, "div_minm1");
    op(0, 32'h8000_0000, 32'd1, "div_min1");
    op(0, 32'd3, 32'hFFFF_FFF9, "div_small");

    for (int i = 0; i < 6; i++) begin
      op(i[0], $urandom, 32'($urandom_range(1, 5000)), "rand");
    end

    // divide aborted by a multiply issued 10 edges later
    sb.push_back(model(1, 32'd6, 32'd7));
    start(0, 1, 32'd100, 32'd7);
    repeat (8) @(negedge clock);
    start(1, 0, 32'd6, 32'd7);
    wait_rdy("abort");
    repeat (40) @(negedge clock);

    // both starts high: multiply takes priority
    sb.push_back(model(1, 32'd20, 32'd3));
    start(1, 1, 32'd20, 32'd3);
    wait_rdy("both");

    // asynchronous reset mid-run
    start(1, 0, 32'd9, 32'd9);
    repeat (10) @(negedge clock);
    @(posedge clock);
    #2 ctrl_reset = 1'b0;
    #1;
    check("arst_busy", 64'(ctrl_busy), 64'd0);
    check("arst_rdy", 64'(data_resultRDY), 64'd0);
    check("arst_res", 64'(data_result), 64'd0);
    check("arst_exc", 64'(data_exception), 64'd0);
    @(negedge clock);
    ctrl_reset = 1'b1;
    repeat (40) @(negedge clock);
    check("arst_idle", 64'(ctrl_busy), 64'd0);
    op(1, 32'd12, 32'hFFFF_FFFB, "post_rst");

    repeat (5) @(negedge clock);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
